// File: rtl/cordic_atan_arbiter_if.sv
// Requester, engine and response signals shared between the atan arbiter and its neighbours.
// master = arbiter side, slave = requesters/engine/response consumer side.
interface cordic_atan_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_x;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_y;
  logic                          eng_start;
  logic [DATA_WIDTH-1:0]         eng_x;
  logic [DATA_WIDTH-1:0]         eng_y;
  logic                          eng_done;
  logic [DATA_WIDTH-1:0]         eng_atan;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_atan;
  logic                          rsp_err;

  modport master (
    input  req_valid, req_x, req_y, eng_done, eng_atan, rsp_ready,
    output req_ready, eng_start, eng_x, eng_y, rsp_valid, rsp_id, rsp_atan, rsp_err
  );

  modport slave (
    output req_valid, req_x, req_y, eng_done, eng_atan, rsp_ready,
    input  req_ready, eng_start, eng_x, eng_y, rsp_valid, rsp_id, rsp_atan, rsp_err
  );
endinterface

// File: rtl/cordic_atan_arbiter.sv
// Round-robin arbiter serialising requesters onto one CORDIC atan engine, one job in flight.
// Define CORDIC_ARB_TIMEOUT_EN to add a watchdog that aborts a hung engine with rsp_err=1.
module cordic_atan_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 40
) (
  input logic                   clk,
  input logic                   rst,
  cordic_atan_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_W-1:0]       last_id;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       cand;
  logic                  grant_found;
  logic [DATA_WIDTH-1:0] sel_x;
  logic [DATA_WIDTH-1:0] sel_y;
  logic [DATA_WIDTH-1:0] eng_x_q;
  logic [DATA_WIDTH-1:0] eng_y_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_atan_q;
  logic                  wd_expired;

  // Search starts one past the last served requester and wraps at NUM_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_x = bus.req_x[i*DATA_WIDTH +: DATA_WIDTH];
        sel_y = bus.req_y[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = BUSY;
      BUSY:    if (bus.eng_done || wd_expired) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_found && !rst) bus.req_ready = NUM_REQ'(1) << grant_id;
    bus.eng_start = (state == ISSUE);
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_x_q    <= '0;
      eng_y_q    <= '0;
      rsp_id_q   <= '0;
      rsp_atan_q <= '0;
      last_id    <= ID_W'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && grant_found) begin
        eng_x_q  <= sel_x;
        eng_y_q  <= sel_y;
        rsp_id_q <= grant_id;
      end
      // A real result beats a watchdog expiry landing in the same cycle.
      if (state == BUSY && bus.eng_done) rsp_atan_q <= bus.eng_atan;
      else if (wd_expired)               rsp_atan_q <= '0;
      if (state == RESP && bus.rsp_ready) last_id <= rsp_id_q;
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd;
  logic            rsp_err_q;

  assign wd_expired = (state == BUSY) && !bus.eng_done && (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd        <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ISSUE)     wd <= '0;
      else if (state == BUSY) wd <= wd + 1'b1;
      if (state == BUSY && bus.eng_done) rsp_err_q <= 1'b0;
      else if (wd_expired)               rsp_err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign wd_expired  = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.eng_x    = eng_x_q;
  assign bus.eng_y    = eng_y_q;
  assign bus.rsp_id   = rsp_id_q;
  assign bus.rsp_atan = rsp_atan_q;
endmodule

// File: tb/tb_cordic_atan_arbiter.sv
// Directed plus randomized bench for cordic_atan_arbiter; the engine is modelled inline and
// grant order comes from a plain round-robin reference over the current request mask.
module tb_cordic_atan_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_atan_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  cordic_atan_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            total = 0;
  int            bad   = 0;
  int            last_m;
  int            w;
  int            n;
  logic [NR-1:0] mask;
  logic [DW-1:0] xs [NR];
  logic [DW-1:0] ys [NR];
  logic [DW-1:0] val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] m, input int last);
    int j;
    for (int k = 1; k <= NR; k++) begin
      j = (last + k) % NR;
      if (m[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    bus.req_valid = mask;
    for (int i = 0; i < NR; i++) begin
      bus.req_x[i*DW +: DW] = xs[i];
      bus.req_y[i*DW +: DW] = ys[i];
    end
  endtask

  // One complete job: grant, start pulse, engine answers in BUSY cycle `lat`, then `bp` stall cycles.
  task automatic txn(input int lat, input int bp, input logic [DW-1:0] atan);
    int            win;
    int            starts;
    logic [DW-1:0] ex;
    logic [DW-1:0] ey;
    win = pick(mask, last_m);
    #1;
    chk("req_ready_grant", 64'(bus.req_ready), 64'(1) << win);
    ex = xs[win];
    ey = ys[win];
    tick();
    starts = int'(bus.eng_start);
    chk("eng_start_issue", 64'(bus.eng_start), 64'(1));
    chk("eng_x", 64'(bus.eng_x), 64'(ex));
    chk("eng_y", 64'(bus.eng_y), 64'(ey));
    chk("req_ready_issue", 64'(bus.req_ready), 64'(0));
    for (int c = 1; c <= lat; c++) begin
      tick();
      starts += int'(bus.eng_start);
      chk("rsp_valid_busy", 64'(bus.rsp_valid), 64'(0));
      chk("eng_x_stable", 64'(bus.eng_x), 64'(ex));
      if (c == lat) begin
        bus.eng_done = 1'b1;
        bus.eng_atan = atan;
      end
    end
    tick();
    bus.eng_done = 1'b0;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("rsp_id", 64'(bus.rsp_id), 64'(win));
    chk("rsp_atan", 64'(bus.rsp_atan), 64'(atan));
    chk("rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("start_count", 64'(starts), 64'(1));
    for (int c = 0; c < bp; c++) begin
      tick();
      chk("bp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("bp_id", 64'(bus.rsp_id), 64'(win));
      chk("bp_atan", 64'(bus.rsp_atan), 64'(atan));
      chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    last_m = win;
  endtask

  initial begin
    mask = '0;
    for (int i = 0; i < NR; i++) begin
      xs[i] = '0;
      ys[i] = '0;
    end
    apply();
    bus.eng_done  = 1'b0;
    bus.eng_atan  = '0;
    bus.rsp_ready = 1'b0;
    last_m        = NR - 1;

    // Reset state, including req_ready suppressed while rst is high.
    tick();
    tick();
    mask = 4'b1111;
    apply();
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_eng_start", 64'(bus.eng_start), 64'(0));
    chk("rst_eng_x", 64'(bus.eng_x), 64'(0));
    chk("rst_eng_y", 64'(bus.eng_y), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_rsp_atan", 64'(bus.rsp_atan), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    tick();
    rst = 1'b0;

    // Contention with all requesters held: order 0,1,2,3,0.
    for (int i = 0; i < NR; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    apply();
    for (int t = 0; t < 5; t++) txn($urandom_range(1, 6), 0, $urandom);

    // Single request from requester 0, engine answers after 20 cycles.
    mask  = 4'b0001;
    xs[0] = 32'd3 << 16;
    ys[0] = 32'd4 << 16;
    apply();
    txn(20, 0, 32'h0035_21B4);
    mask = '0;
    apply();

    // Stray eng_done while idle produces nothing.
    bus.eng_done = 1'b1;
    bus.eng_atan = 32'hDEAD_BEEF;
    tick();
    bus.eng_done = 1'b0;
    chk("stray_idle_valid", 64'(bus.rsp_valid), 64'(0));
    chk("stray_idle_start", 64'(bus.eng_start), 64'(0));
    tick();
    chk("stray_idle_valid2", 64'(bus.rsp_valid), 64'(0));

    // Backpressure: ten stalled cycles with other requesters waiting.
    mask = 4'b1010;
    apply();
    txn(5, 10, 32'h1234_5678);

    // A request withdrawn before any edge leaves no trace.
    mask = 4'b0100;
    apply();
    #1;
    chk("withdraw_ready", 64'(bus.req_ready), 64'(4'b0100));
    mask = '0;
    apply();
    tick();
    chk("withdraw_no_start", 64'(bus.eng_start), 64'(0));
    mask = 4'b0101;
    apply();
    txn(3, 1, 32'h0BAD_F00D);
    mask = '0;
    apply();

    // Hung engine.
    mask = 4'b0100;
    apply();
    w = pick(mask, last_m);
    #1;
    tick();
    mask = '0;
    apply();
    tick();
`ifdef CORDIC_ARB_TIMEOUT_EN
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("wd_busy_cycles", 64'(n), 64'(TO));
    chk("wd_err", 64'(bus.rsp_err), 64'(1));
    chk("wd_atan", 64'(bus.rsp_atan), 64'(0));
    chk("wd_id", 64'(bus.rsp_id), 64'(w));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    last_m = w;
    // eng_done in the expiry cycle wins.
    mask = 4'b1000;
    apply();
    w = pick(mask, last_m);
    #1;
    tick();
    mask = '0;
    apply();
    tick();
    repeat (TO - 1) tick();
    chk("wd_edge_pending", 64'(bus.rsp_valid), 64'(0));
    bus.eng_done = 1'b1;
    bus.eng_atan = 32'h7777_0001;
    tick();
    bus.eng_done = 1'b0;
    chk("wd_edge_valid", 64'(bus.rsp_valid), 64'(1));
    chk("wd_edge_err", 64'(bus.rsp_err), 64'(0));
    chk("wd_edge_atan", 64'(bus.rsp_atan), 64'(32'h7777_0001));
    chk("wd_edge_id", 64'(bus.rsp_id), 64'(w));
`else
    n = 0;
    repeat (60) begin
      tick();
      if (bus.rsp_valid) n++;
    end
    chk("nowd_no_response", 64'(n), 64'(0));
    chk("nowd_err", 64'(bus.rsp_err), 64'(0));
    bus.eng_done = 1'b1;
    bus.eng_atan = 32'h7777_0002;
    tick();
    bus.eng_done = 1'b0;
    chk("nowd_late_valid", 64'(bus.rsp_valid), 64'(1));
    chk("nowd_late_atan", 64'(bus.rsp_atan), 64'(32'h7777_0002));
    chk("nowd_late_id", 64'(bus.rsp_id), 64'(w));
`endif
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    last_m = w;

    // Reset mid-BUSY: asynchronous clear, no response, pointer back to the bottom.
    mask = 4'b0010;
    xs[1] = 32'hA5A5_0001;
    ys[1] = 32'h5A5A_0002;
    apply();
    #1;
    tick();
    tick();
    tick();
    tick();
    #3;
    rst  = 1'b1;
    mask = 4'b1111;
    apply();
    #1;
    chk("arst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("arst_eng_start", 64'(bus.eng_start), 64'(0));
    chk("arst_eng_x", 64'(bus.eng_x), 64'(0));
    chk("arst_eng_y", 64'(bus.eng_y), 64'(0));
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("arst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("arst_rsp_atan", 64'(bus.rsp_atan), 64'(0));
    tick();
    tick();
    rst  = 1'b0;
    mask = '0;
    apply();
    last_m = NR - 1;
    bus.eng_done = 1'b1;
    bus.eng_atan = 32'hFFFF_0000;
    tick();
    bus.eng_done = 1'b0;
    n = 0;
    repeat (4) begin
      if (bus.rsp_valid) n++;
      tick();
    end
    chk("arst_stray_done", 64'(n), 64'(0));
    mask = 4'b0110;
    apply();
    txn(4, 0, 32'h0000_4321);

    // Randomized masks, operands, engine latency and response stalls.
    for (int t = 0; t < 30; t++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        xs[i] = $urandom;
        ys[i] = $urandom;
      end
      apply();
      val = $urandom;
      txn($urandom_range(1, 8), $urandom_range(0, 3), val);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_atan_arbiter.md
CORDIC_ATAN_ARBITER -- requirements
Module: cordic_atan_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 32, coordinate and angle width.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 40, watchdog limit in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester request.
- req_ready, out, NUM_REQ, per-requester accept (one-hot or zero).
- req_x, in, NUM_REQ*DATA_WIDTH, packed signed x; requester i occupies slice i.
- req_y, in, NUM_REQ*DATA_WIDTH, packed signed y; requester i occupies slice i.
- eng_start, out, 1, one-cycle start pulse to the atan engine.
- eng_x, out, DATA_WIDTH, latched x to the engine.
- eng_y, out, DATA_WIDTH, latched y to the engine.
- eng_done, in, 1, engine result valid.
- eng_atan, in, DATA_WIDTH, engine angle.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, response accept.
- rsp_id, out, clog2(NUM_REQ), index of the served requester.
- rsp_atan, out, DATA_WIDTH, angle result.
- rsp_err, out, 1, watchdog abort flag.
REQ-003 The design SHALL use one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, BUSY and RESP.
REQ-005 In IDLE, req_ready SHALL combinationally assert for one winner among the asserted req_valid bits, searching round-robin from (last_id+1) mod NUM_REQ.
REQ-006 The transfer SHALL occur on a req_valid&req_ready cycle: latch x/y into eng_x/eng_y, latch the winner into rsp_id, then go to ISSUE.
REQ-007 In any state other than IDLE, req_ready SHALL be all zeros.
REQ-008 ISSUE SHALL drive eng_start=1 for exactly one cycle, then go to BUSY.
REQ-009 eng_x/eng_y SHALL hold stable from ISSUE through the end of BUSY.
REQ-010 In BUSY, eng_done=1 SHALL capture eng_atan into rsp_atan, clear rsp_err and go to RESP.
REQ-011 In RESP, rsp_valid SHALL be 1, and rsp_id/rsp_atan/rsp_err SHALL hold until rsp_ready=1; on that cycle the block SHALL set last_id to rsp_id and go to IDLE.
REQ-012 Latency SHALL be: accept at cycle 0, eng_start at cycle 1, rsp_valid one cycle after eng_done.
REQ-013 eng_done outside BUSY SHALL be ignored.
REQ-014 Requests arriving while the block is busy SHALL wait, with no loss, as long as the requester holds req_valid.
REQ-015 Deasserting req_valid without a transfer SHALL have no effect.
REQ-016 Round-robin pointer wrap-around: after id NUM_REQ-1, the search SHALL start at id 0.

Reset
REQ-017 While rst=1, outputs SHALL be: state=IDLE, req_ready=0, eng_start=0, eng_x=0, eng_y=0, rsp_valid=0, rsp_id=0, rsp_atan=0, rsp_err=0, and internally last_id=NUM_REQ-1 and watchdog=0.
REQ-018 Reset mid-operation SHALL abandon the transaction with no response issued; the first grant after reset SHALL go to the lowest asserted index.

Configuration
REQ-019 Macro CORDIC_ARB_TIMEOUT_EN defined: a watchdog counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-020 With the macro defined, a count of TIMEOUT without eng_done SHALL force RESP with rsp_atan=0 and rsp_err=1; eng_done in the same cycle SHALL win (normal result, rsp_err=0).
REQ-021 With the macro undefined, no counter SHALL exist, rsp_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-022 Single request: req_valid=0001 with x=3<<16, y=4<<16; engine returns 0x0035_21B4 after 20 cycles -> exactly one eng_start, rsp_id=0, rsp_atan=0x0035_21B4, rsp_valid 1 cycle after eng_done.
REQ-023 Contention: req_valid=1111 held across four transactions -> grant order 0,1,2,3, then 0 again on the fifth.
REQ-024 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and data stable, req_ready=0 throughout, next grant only after the rsp_ready handshake.
REQ-025 Watchdog (macro defined, TIMEOUT=40): eng_done never asserted -> rsp_valid after 40 BUSY cycles, rsp_err=1, rsp_atan=0; eng_done and the timeout in the same cycle -> rsp_err=0.
REQ-026 Reset mid-BUSY: rst pulsed -> all outputs 0 asynchronously; a later stray eng_done produces no response; the next grant goes to the lowest asserted index.
